memory_stage2: RTL and testbench
================================

MEMORY_STAGE2 -- requirements
Module: memory_stage2

Interface
REQ-001 SHALL provide port CLK, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL provide port RST, input, 1, reset, synchronous and active-high.
REQ-003 SHALL provide inputs V (1), RD_ADDR1_V (1), RA_RD_ADDR1 (32), RA_RD_SIZE1 (4), RD_ADDR2_V (1), RA_RD_ADDR2 (32), RA_RD_SIZE2 (4): stage-valid plus first/second physical read access; size is a byte count 1..4.
REQ-004 SHALL provide inputs MEM_DEP_STALL (1), PAGE_FAULT_EXC (1), GPROT_EXC (1): dependency hold and exception flags from the preceding stage.
REQ-005 SHALL provide input WB_STALL (1): downstream latch cannot accept this cycle.
REQ-006 SHALL provide outputs DC_RD_REQ (1), DC_RD_ADDR (32), DC_RD_SIZE (4) and inputs DC_RD_ACK (1), DC_RD_DATA (32): data-cache read port; data right-justified, byte at DC_RD_ADDR in bits 7:0.
REQ-007 SHALL provide outputs V_OUT (1), MEM_RD_DATA_OUT (32), EXC_OUT (1), STALL_OUT (1): result valid, merged little-endian read data, exception flag, upstream hold.

Function
REQ-008 SHALL implement FSM states IDLE, RD1, RD2, DONE.
REQ-009 IDLE: SHALL capture all access fields and go to RD1 when V & RD_ADDR1_V & !MEM_DEP_STALL & !PAGE_FAULT_EXC & !GPROT_EXC; otherwise remain IDLE.
REQ-010 IDLE with V & !RD_ADDR1_V & !MEM_DEP_STALL, or V with any exception flag: SHALL assert V_OUT combinationally that cycle (EXC_OUT = PAGE_FAULT_EXC | GPROT_EXC, data 0), issue no cache request.
REQ-011 RD1: SHALL drive DC_RD_REQ=1 with captured addr1/size1; on DC_RD_ACK latch data1, go to RD2 if captured RD_ADDR2_V else DONE.
REQ-012 RD2: SHALL drive DC_RD_REQ=1 with captured addr2/size2; on DC_RD_ACK go to DONE.
REQ-013 Merge SHALL be: bytes 0..size1-1 from data1; bytes size1..size1+size2-1 from data2 bytes 0..size2-1; remaining bytes zero. size1+size2 > 4 is illegal input; result unspecified.
REQ-014 DONE: SHALL hold V_OUT=1 and stable MEM_RD_DATA_OUT; go to IDLE on the first cycle with !WB_STALL.
REQ-015 STALL_OUT SHALL be 1 in RD1, RD2, and in DONE while WB_STALL; 0 in IDLE.
REQ-016 Upstream inputs SHALL be ignored outside IDLE.
REQ-017 Latency: an ACK in the first RD1 cycle SHALL give V_OUT two cycles after capture (single access), three cycles for a split access with immediate ACKs.
REQ-018 DC_RD_REQ SHALL be 0 in IDLE and DONE, and each access SHALL be issued exactly once.
REQ-019 DC_RD_ACK outside RD1/RD2 SHALL be ignored.

Reset
REQ-020 RST SHALL force IDLE and clear captured fields and the data register, overriding any in-progress access on the same edge.
REQ-021 After reset, V_OUT, DC_RD_REQ, STALL_OUT, EXC_OUT SHALL be 0 and MEM_RD_DATA_OUT SHALL be 0.
REQ-022 A DC_RD_ACK arriving on or after a mid-operation reset SHALL not produce V_OUT.

Structure
REQ-023 State encodings (2-bit) and size-range constants SHALL reside in the shared pipeline constants include.
REQ-024 The byte-merge logic SHALL be one sub-module, rd_data_merge (data1, size1, data2, size2 -> merged).

Verification
REQ-025 Single read: addr1=0x1000, size1=4, ACK in the first RD1 cycle with 0xDEADBEEF -> V_OUT two cycles after capture, data 0xDEADBEEF, STALL_OUT high for one cycle.
REQ-026 Split read: addr1=0x1FFE size1=2 data1=0x0000BBAA; addr2=0x2000 size2=2 data2=0x0000DDCC -> data 0xDDCCBBAA, two DC_RD_REQ phases.
REQ-027 Delayed ACK (5 cycles) plus WB_STALL held 3 cycles in DONE -> request held stable, V_OUT held 3 cycles with constant data, then IDLE.
REQ-028 V=1, RD_ADDR1_V=1, MEM_DEP_STALL=1 for 4 cycles -> no DC_RD_REQ, no V_OUT until stall drops.
REQ-029 PAGE_FAULT_EXC=1 with RD_ADDR1_V=1 -> V_OUT and EXC_OUT same cycle, DC_RD_REQ never asserted.
REQ-030 RST in RD2 -> next cycle IDLE, all outputs 0, late DC_RD_ACK produces no V_OUT.

Source files
------------

// File: rtl/memory_stage2_pkg.sv
// Shared constants for the memory read stage.
// State encodings, access-size range and bus widths.
package memory_stage2_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SIZE_W   = 4;
  localparam int SIZE_MIN = 1;
  localparam int SIZE_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_RD2  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/memory_stage2_if.sv
// Upstream access, data-cache port and result bundle
// of the memory read stage.
interface memory_stage2_if;
  import memory_stage2_pkg::*;

  logic              V;
  logic              RD_ADDR1_V;
  logic [ADDR_W-1:0] RA_RD_ADDR1;
  logic [SIZE_W-1:0] RA_RD_SIZE1;
  logic              RD_ADDR2_V;
  logic [ADDR_W-1:0] RA_RD_ADDR2;
  logic [SIZE_W-1:0] RA_RD_SIZE2;
  logic              MEM_DEP_STALL;
  logic              PAGE_FAULT_EXC;
  logic              GPROT_EXC;
  logic              WB_STALL;

  logic              DC_RD_REQ;
  logic [ADDR_W-1:0] DC_RD_ADDR;
  logic [SIZE_W-1:0] DC_RD_SIZE;
  logic              DC_RD_ACK;
  logic [DATA_W-1:0] DC_RD_DATA;

  logic              V_OUT;
  logic [DATA_W-1:0] MEM_RD_DATA_OUT;
  logic              EXC_OUT;
  logic              STALL_OUT;

  modport slave (
    input  V, RD_ADDR1_V, RA_RD_ADDR1, RA_RD_SIZE1,
    input  RD_ADDR2_V, RA_RD_ADDR2, RA_RD_SIZE2,
    input  MEM_DEP_STALL, PAGE_FAULT_EXC, GPROT_EXC,
    input  WB_STALL, DC_RD_ACK, DC_RD_DATA,
    output DC_RD_REQ, DC_RD_ADDR, DC_RD_SIZE,
    output V_OUT, MEM_RD_DATA_OUT, EXC_OUT, STALL_OUT
  );

  modport master (
    output V, RD_ADDR1_V, RA_RD_ADDR1, RA_RD_SIZE1,
    output RD_ADDR2_V, RA_RD_ADDR2, RA_RD_SIZE2,
    output MEM_DEP_STALL, PAGE_FAULT_EXC, GPROT_EXC,
    output WB_STALL, DC_RD_ACK, DC_RD_DATA,
    input  DC_RD_REQ, DC_RD_ADDR, DC_RD_SIZE,
    input  V_OUT, MEM_RD_DATA_OUT, EXC_OUT, STALL_OUT
  );

endinterface

// File: rtl/memory_stage2_rd_data_merge.sv
// Little-endian merge of two right-justified partial reads:
// data1 low bytes, then data2 bytes, zero above.
module rd_data_merge
  import memory_stage2_pkg::*;
(
  input  logic [DATA_W-1:0] i_data1,
  input  logic [SIZE_W-1:0] i_size1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [SIZE_W-1:0] i_size2,
  output logic [DATA_W-1:0] o_merged
);

  logic [4:0]        w_end;
  logic [6:0]        w_sh;
  logic [DATA_W-1:0] w_d2_sh;

  assign w_end   = {1'b0, i_size1} + {1'b0, i_size2};
  assign w_sh    = {i_size1, 3'b000};
  // data2 byte 0 lands at byte lane size1
  assign w_d2_sh = i_data2 << w_sh;

  always_comb begin
    o_merged = '0;
    for (int i = 0; i < SIZE_MAX; i++) begin
      if (5'(i) < {1'b0, i_size1})
        o_merged[8*i +: 8] = i_data1[8*i +: 8];
      else if (5'(i) < w_end)
        o_merged[8*i +: 8] = w_d2_sh[8*i +: 8];
    end
  end

endmodule

// File: rtl/memory_stage2.sv
// Memory read stage: issues one or two data-cache reads
// per access and returns the merged little-endian result.
module memory_stage2
  import memory_stage2_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  memory_stage2_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  logic [SIZE_W-1:0] r_size1;
  logic [SIZE_W-1:0] r_size2;
  logic              r_addr2_v;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data;

  logic              w_exc;
  logic              w_go;
  logic              w_bypass;
  logic              w_ack1;
  logic              w_ack2;
  logic [DATA_W-1:0] w_m_d1;
  logic [SIZE_W-1:0] w_m_s2;
  logic [DATA_W-1:0] w_merged;

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic [SIZE_W-1:0] w_size;
  logic              w_stall;
  logic              w_vout;
  logic              w_exc_out;
  logic [DATA_W-1:0] w_rdata;

  assign w_exc    = bus.PAGE_FAULT_EXC | bus.GPROT_EXC;
  assign w_go     = bus.V & bus.RD_ADDR1_V
                  & ~bus.MEM_DEP_STALL & ~w_exc;
  assign w_bypass = bus.V
                  & ((~bus.RD_ADDR1_V & ~bus.MEM_DEP_STALL)
                  | w_exc);
  assign w_ack1   = (r_state == ST_RD1) & bus.DC_RD_ACK;
  assign w_ack2   = (r_state == ST_RD2) & bus.DC_RD_ACK;

  // single access merges live data with an empty second part
  assign w_m_d1 = (r_state == ST_RD1) ? bus.DC_RD_DATA
                                      : r_data1;
  assign w_m_s2 = (r_state == ST_RD2) ? r_size2 : '0;

  rd_data_merge u_merge (
    .i_data1  (w_m_d1),
    .i_size1  (r_size1),
    .i_data2  (bus.DC_RD_DATA),
    .i_size2  (w_m_s2),
    .o_merged (w_merged)
  );

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_addr    = '0;
    w_size    = '0;
    w_stall   = 1'b0;
    w_vout    = 1'b0;
    w_exc_out = 1'b0;
    w_rdata   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_go)
          w_next = ST_RD1;
        if (w_bypass) begin
          w_vout    = 1'b1;
          w_exc_out = w_exc;
        end
      end
      ST_RD1: begin
        w_req   = 1'b1;
        w_addr  = r_addr1;
        w_size  = r_size1;
        w_stall = 1'b1;
        if (bus.DC_RD_ACK)
          w_next = r_addr2_v ? ST_RD2 : ST_DONE;
      end
      ST_RD2: begin
        w_req   = 1'b1;
        w_addr  = r_addr2;
        w_size  = r_size2;
        w_stall = 1'b1;
        if (bus.DC_RD_ACK)
          w_next = ST_DONE;
      end
      ST_DONE: begin
        w_vout  = 1'b1;
        w_rdata = r_data;
        w_stall = bus.WB_STALL;
        if (!bus.WB_STALL)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_addr1   <= '0;
      r_addr2   <= '0;
      r_size1   <= '0;
      r_size2   <= '0;
      r_addr2_v <= 1'b0;
      r_data1   <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_go) begin
        r_addr1   <= bus.RA_RD_ADDR1;
        r_size1   <= bus.RA_RD_SIZE1;
        r_addr2_v <= bus.RD_ADDR2_V;
        r_addr2   <= bus.RA_RD_ADDR2;
        r_size2   <= bus.RA_RD_SIZE2;
      end
      if (w_ack1)
        r_data1 <= bus.DC_RD_DATA;
      if ((w_ack1 && !r_addr2_v) || w_ack2)
        r_data <= w_merged;
    end
  end

  assign bus.DC_RD_REQ       = w_req;
  assign bus.DC_RD_ADDR      = w_addr;
  assign bus.DC_RD_SIZE      = w_size;
  assign bus.STALL_OUT       = w_stall;
  assign bus.V_OUT           = w_vout;
  assign bus.EXC_OUT         = w_exc_out;
  assign bus.MEM_RD_DATA_OUT = w_rdata;

endmodule

// File: tb/tb_memory_stage2.sv
// Directed bench for memory_stage2.
// Flags are {V_OUT, DC_RD_REQ, STALL_OUT, EXC_OUT}.
module tb_memory_stage2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  memory_stage2_if bus ();

  memory_stage2 dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [3:0] flags;
  assign flags = {bus.V_OUT, bus.DC_RD_REQ,
                  bus.STALL_OUT, bus.EXC_OUT};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    bus.V              = 1'b0;
    bus.RD_ADDR1_V     = 1'b0;
    bus.RA_RD_ADDR1    = '0;
    bus.RA_RD_SIZE1    = '0;
    bus.RD_ADDR2_V     = 1'b0;
    bus.RA_RD_ADDR2    = '0;
    bus.RA_RD_SIZE2    = '0;
    bus.MEM_DEP_STALL  = 1'b0;
    bus.PAGE_FAULT_EXC = 1'b0;
    bus.GPROT_EXC      = 1'b0;
    bus.WB_STALL       = 1'b0;
    bus.DC_RD_ACK      = 1'b0;
    bus.DC_RD_DATA     = '0;
  endtask

  task automatic issue(input logic [31:0] a1,
                       input logic [3:0]  s1,
                       input logic        a2v,
                       input logic [31:0] a2,
                       input logic [3:0]  s2);
    bus.V           = 1'b1;
    bus.RD_ADDR1_V  = 1'b1;
    bus.RA_RD_ADDR1 = a1;
    bus.RA_RD_SIZE1 = s1;
    bus.RD_ADDR2_V  = a2v;
    bus.RA_RD_ADDR2 = a2;
    bus.RA_RD_SIZE2 = s2;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", flags);
    end
    checks++;
    if (bus.MEM_RD_DATA_OUT !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0",
               bus.MEM_RD_DATA_OUT);
    end
  endtask

  task automatic test_single();
    tick();
    issue(32'h1000, 4'd4, 1'b0, 32'h0, 4'd0);
    settle();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL single_capture got %b exp 0000", flags);
    end
    tick();
    quiet();
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = 32'hDEADBEEF;
    settle();
    checks++;
    if ({flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE}
        !== {4'b0110, 32'h1000, 4'd4}) begin
      errors++;
      $display("FAIL single_rd1 got %b %h %0d exp 0110 1000 4",
               flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE);
    end
    tick();
    quiet();
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT}
        !== {4'b1000, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_done got %b %h exp 1000 deadbeef",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle got %b exp 0000", flags);
    end
  endtask

  task automatic test_split(input logic [31:0] a1,
                            input logic [3:0]  s1,
                            input logic [31:0] d1,
                            input logic [31:0] a2,
                            input logic [3:0]  s2,
                            input logic [31:0] d2,
                            input logic [31:0] exp);
    tick();
    issue(a1, s1, 1'b1, a2, s2);
    tick();
    quiet();
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = d1;
    settle();
    checks++;
    if ({flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE}
        !== {4'b0110, a1, s1}) begin
      errors++;
      $display("FAIL split_rd1 got %b %h %0d exp 0110 %h %0d",
               flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE, a1, s1);
    end
    tick();
    bus.DC_RD_DATA = d2;
    settle();
    checks++;
    if ({flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE}
        !== {4'b0110, a2, s2}) begin
      errors++;
      $display("FAIL split_rd2 got %b %h %0d exp 0110 %h %0d",
               flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE, a2, s2);
    end
    tick();
    quiet();
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT} !== {4'b1000, exp}) begin
      errors++;
      $display("FAIL split_done got %b %h exp 1000 %h",
               flags, bus.MEM_RD_DATA_OUT, exp);
    end
    tick();
  endtask

  task automatic test_delayed();
    tick();
    issue(32'h3000, 4'd4, 1'b0, 32'h0, 4'd0);
    tick();
    issue(32'h4444, 4'd1, 1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if ({flags, bus.DC_RD_ADDR, bus.DC_RD_SIZE}
          !== {4'b0110, 32'h3000, 4'd4}) begin
        errors++;
        $display("FAIL delay_hold%0d got %b %h exp 0110 3000",
                 i, flags, bus.DC_RD_ADDR);
      end
      tick();
    end
    quiet();
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = 32'hCAFEF00D;
    bus.WB_STALL   = 1'b1;
    tick();
    bus.DC_RD_ACK  = 1'b0;
    bus.DC_RD_DATA = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({flags, bus.MEM_RD_DATA_OUT}
          !== {4'b1010, 32'hCAFEF00D}) begin
        errors++;
        $display("FAIL delay_wb%0d got %b %h exp 1010 cafef00d",
                 i, flags, bus.MEM_RD_DATA_OUT);
      end
      tick();
    end
    bus.WB_STALL = 1'b0;
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT}
        !== {4'b1000, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL delay_release got %b %h exp 1000 cafef00d",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL delay_idle got %b exp 0000", flags);
    end
  endtask

  task automatic test_dep_stall();
    tick();
    issue(32'h5000, 4'd4, 1'b0, 32'h0, 4'd0);
    bus.MEM_DEP_STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (flags !== 4'b0000) begin
        errors++;
        $display("FAIL dep_hold%0d got %b exp 0000", i, flags);
      end
      tick();
    end
    bus.MEM_DEP_STALL = 1'b0;
    tick();
    quiet();
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = 32'h01020304;
    settle();
    checks++;
    if ({flags, bus.DC_RD_ADDR} !== {4'b0110, 32'h5000}) begin
      errors++;
      $display("FAIL dep_rd1 got %b %h exp 0110 5000",
               flags, bus.DC_RD_ADDR);
    end
    tick();
    quiet();
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT}
        !== {4'b1000, 32'h01020304}) begin
      errors++;
      $display("FAIL dep_done got %b %h exp 1000 01020304",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
  endtask

  task automatic test_bypass();
    bus.V = 1'b1;
    bus.DC_RD_ACK = 1'b1;
    bus.DC_RD_DATA = 32'hFFFFFFFF;
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL bypass_noaddr got %b %h exp 1000 0",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
    quiet();
    issue(32'h6000, 4'd4, 1'b0, 32'h0, 4'd0);
    bus.PAGE_FAULT_EXC = 1'b1;
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT} !== {4'b1001, 32'h0}) begin
      errors++;
      $display("FAIL bypass_pf got %b %h exp 1001 0",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
    bus.PAGE_FAULT_EXC = 1'b0;
    bus.GPROT_EXC = 1'b1;
    settle();
    checks++;
    if (flags !== 4'b1001) begin
      errors++;
      $display("FAIL bypass_gp got %b exp 1001", flags);
    end
    tick();
    quiet();
    settle();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_after got %b exp 0000", flags);
    end
    tick();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_noreq got %b exp 0000", flags);
    end
  endtask

  task automatic test_reset_rd2();
    tick();
    issue(32'h7FFE, 4'd2, 1'b1, 32'h8000, 4'd2);
    tick();
    quiet();
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = 32'h00002211;
    tick();
    bus.DC_RD_ACK = 1'b0;
    settle();
    checks++;
    if ({flags, bus.DC_RD_ADDR} !== {4'b0110, 32'h8000}) begin
      errors++;
      $display("FAIL rst_rd2 got %b %h exp 0110 8000",
               flags, bus.DC_RD_ADDR);
    end
    rst = 1'b1;
    bus.DC_RD_ACK  = 1'b1;
    bus.DC_RD_DATA = 32'h00004433;
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if ({flags, bus.MEM_RD_DATA_OUT} !== {4'b0000, 32'h0}) begin
      errors++;
      $display("FAIL rst_after got %b %h exp 0000 0",
               flags, bus.MEM_RD_DATA_OUT);
    end
    tick();
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_late_ack got %b exp 0000", flags);
    end
    quiet();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    test_reset();
    test_single();
    test_split(32'h1FFE, 4'd2, 32'h0000BBAA,
               32'h2000, 4'd2, 32'h0000DDCC, 32'hDDCCBBAA);
    test_split(32'h0101, 4'd1, 32'h11223344,
               32'h0102, 4'd2, 32'h55667788, 32'h00778844);
    test_split(32'h0203, 4'd3, 32'hAABBCCDD,
               32'h0206, 4'd1, 32'h123456EE, 32'hEEBBCCDD);
    test_delayed();
    test_dep_stall();
    test_bypass();
    test_reset_rd2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
